// File: rtl/counter_pkg.sv
// Shared definitions for the PWM period counter and its comparator.
// COUNTER_ONESHOT_EN selects saturate-and-hold instead of wrap in next_count.
package counter_pkg;

  localparam int COUNTER_DEFAULT_WIDTH = 16;

  // Operates on 32-bit zero-extended values so any BIT_WIDTH up to 32 can share it.
  function automatic logic [31:0] next_count(input logic [31:0] count,
                                             input logic [31:0] max);
`ifdef COUNTER_ONESHOT_EN
    return (count >= max) ? max : count + 32'd1;
`else
    return (count >= max) ? 32'd0 : count + 32'd1;
`endif
  endfunction

endpackage

// File: rtl/counter.sv
// PWM period timebase: counts 0..MaxCount while enabled, flags terminal count on Done.
// Both outputs registered; COUNTER_ONESHOT_EN makes it stop at MaxCount instead of wrapping.
module counter
  import counter_pkg::*;
#(
  parameter int BIT_WIDTH = COUNTER_DEFAULT_WIDTH
) (
  input  logic                 MClk,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic [BIT_WIDTH-1:0] MaxCount,
  output logic                 Done,
  output logic [BIT_WIDTH-1:0] Count
);

  logic [BIT_WIDTH-1:0] count_q, count_d;
  logic                 done_q, done_d;

  // Done tracks the value being loaded, so it is high exactly while Count==MaxCount.
  always_comb begin
    count_d = '0;
    done_d  = 1'b0;
    if (Enable) begin
      count_d = BIT_WIDTH'(next_count(32'(count_q), 32'(MaxCount)));
      done_d  = (count_d == MaxCount);
    end
  end

  always_ff @(posedge MClk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign Count = count_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_counter.sv
// Randomized self-checking bench for counter at BIT_WIDTH 16 and 4 against a behavioural model.
module tb_counter;

  logic        MClk = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b0;
  logic [15:0] max16 = 16'd0;
  logic [3:0]  max4 = 4'd0;
  logic        done16, done4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference state
  int m16_cnt = 0, m4_cnt = 0;
  bit m16_done = 0, m4_done = 0;

  always #5 MClk = ~MClk;

  counter #(.BIT_WIDTH(16)) u_dut16 (
    .MClk(MClk), .Reset(Reset), .Enable(Enable),
    .MaxCount(max16), .Done(done16), .Count(cnt16)
  );

  counter #(.BIT_WIDTH(4)) u_dut4 (
    .MClk(MClk), .Reset(Reset), .Enable(Enable),
    .MaxCount(max4), .Done(done4), .Count(cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, act, act, exp, exp, cyc);
    end
  endtask

  // Spec rule: below the terminal count step up; at or above it wrap (or hold in one-shot).
  function automatic int model_next(int c, int m);
    if (c < m) return c + 1;
`ifdef COUNTER_ONESHOT_EN
    return m;
`else
    return 0;
`endif
  endfunction

  task automatic model_edge();
    if (Reset || !Enable) begin
      m16_cnt = 0; m16_done = 0;
      m4_cnt  = 0; m4_done  = 0;
    end else begin
      m16_cnt  = model_next(m16_cnt, int'(max16));
      m16_done = (m16_cnt == int'(max16));
      m4_cnt   = model_next(m4_cnt, int'(max4));
      m4_done  = (m4_cnt == int'(max4));
    end
  endtask

  task automatic step(input string tag);
    @(posedge MClk);
    model_edge();
    cyc++;
    #1;
    chk({tag, "_cnt16"}, 32'(cnt16), 32'(m16_cnt));
    chk({tag, "_done16"}, 32'(done16), 32'(m16_done));
    chk({tag, "_cnt4"}, 32'(cnt4), 32'(m4_cnt));
    chk({tag, "_done4"}, 32'(done4), 32'(m4_done));
  endtask

  initial begin
    int last_done;
    int npulse;

    // Reset state
    #2;
    chk("rst_cnt16", 32'(cnt16), 32'd0);
    chk("rst_done16", 32'(done16), 32'd0);
    step("rst_hold");
    Reset = 1'b0;

    // Disabled for 3 cycles, then free-run with MaxCount=500 for 4 periods
    Enable = 1'b0; max16 = 16'd500; max4 = 4'd15;
    repeat (3) step("dis");
    Enable = 1'b1;
    last_done = -1; npulse = 0;
    repeat (4 * 501) begin
      step("p500");
`ifndef COUNTER_ONESHOT_EN
      if (done16 === 1'b1) begin
        chk("done_at_max", 32'(cnt16), 32'd500);
        if (last_done >= 0) chk("done_period", 32'(cyc - last_done), 32'd501);
        last_done = cyc;
        npulse++;
      end
`endif
    end
`ifndef COUNTER_ONESHOT_EN
    chk("done_pulses", 32'(npulse), 32'd4);
`endif

    // Lower MaxCount below the current count mid-period
    repeat (300) step("to300");
    max16 = 16'd100;
    step("trunc");
    repeat (110) step("after_trunc");

    // Asynchronous reset at Count=123
    Enable = 1'b0; max16 = 16'd500;
    step("pre_async");
    Enable = 1'b1;
    repeat (123) step("to123");
    chk("at123", 32'(cnt16), 32'd123);
    #2 Reset = 1'b1;
    #1;
    chk("async_cnt", 32'(cnt16), 32'd0);
    chk("async_done", 32'(done16), 32'd0);
    m16_cnt = 0; m16_done = 0; m4_cnt = 0; m4_done = 0;
    step("rst_mid");
    Reset = 1'b0;
    step("rel");
    chk("rel_first", 32'(cnt16), 32'd1);

    // MaxCount=0 keeps Count at 0 with Done continuously high
    max16 = 16'd0; max4 = 4'd0;
    repeat (6) step("max0");
    chk("max0_done", 32'(done16), 32'd1);
    Enable = 1'b0;
    step("max0_off");
    chk("max0_off_done", 32'(done16), 32'd0);

    // All-ones MaxCount on the 4-bit instance, several wraps
    Enable = 1'b1; max4 = 4'hF; max16 = 16'd7;
    repeat (50) step("max4_ff");

    // Random enable / MaxCount / reset activity
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) Enable = ~Enable;
      else if (!Enable && $urandom_range(0, 3) == 0) Enable = 1'b1;
      if ($urandom_range(0, 79) == 0) max16 = 16'($urandom_range(0, 40));
      if ($urandom_range(0, 49) == 0) max4 = 4'($urandom_range(0, 15));
      Reset = ($urandom_range(0, 299) == 0);
      step("rand");
    end
    Reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
